// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and stage-record layout for the control-path pipeline.
// A stage record is packed as {flags, rd, ctrl}, with ctrl in the low bits.
package ctrl_pipe_pkg;

  localparam int FWD_RF = 0;
  localparam int STG_E  = 0;
  localparam int STG_M  = 1;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic load;
  } stg_flags_t;

  localparam int FLAGS_W = $bits(stg_flags_t);

  function automatic int rec_w(input int ctrl_w, input int reg_aw);
    return FLAGS_W + reg_aw + ctrl_w;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage record register.
// Reset or clr zeroes the whole record; otherwise it loads every cycle.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_q <= '0;
    else                  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Parametrised control pipeline (E..W) with load-use stall, branch flush,
// Execute-stage forwarding selects and saturating stall/flush counters.
module ctrl_pipe_hazard
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W   = 16,
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int FW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_d,
  input  logic [CTRL_W-1:0]         ctrl_d,
  input  logic [REG_AW-1:0]         rd_d,
  input  logic [REG_AW-1:0]         rs1_d,
  input  logic [REG_AW-1:0]         rs2_d,
  input  logic                      regwrite_d,
  input  logic                      load_d,
  input  logic                      pcsrc_e,
  output logic [DEPTH*CTRL_W-1:0]   ctrl_q,
  output logic [DEPTH-1:0]          valid_q,
  output logic [REG_AW-1:0]         rd_w,
  output logic                      regwrite_w,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [FW-1:0]             fwd_a_e,
  output logic [FW-1:0]             fwd_b_e,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam int REC_W  = rec_w(CTRL_W, REG_AW);
  localparam int RD_LSB = CTRL_W;
  localparam int FL_LSB = CTRL_W + REG_AW;
  localparam int S0_W   = REC_W + 2 * REG_AW;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [DEPTH-1:0][REC_W-1:0] w_rec;
  logic [REG_AW-1:0]           w_rs1_e;
  logic [REG_AW-1:0]           w_rs2_e;
  logic [DEPTH-1:0]            w_vld;
  logic [DEPTH-1:0]            w_rw;
  logic [DEPTH-1:0]            w_ld;
  logic [REG_AW-1:0]           w_rd [DEPTH];
  stg_flags_t                  w_fl_d;
  logic                        w_lu;
  logic                        w_br;
  logic [31:0]                 r_stall_cnt;
  logic [31:0]                 r_flush_cnt;

  assign w_fl_d = '{valid: valid_d, regwrite: regwrite_d, load: load_d};

  // ---- stage registers: E captures D (bubble on flush_e), later stages shift
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      stg_flags_t w_fl;
      if (k == 0) begin : g_e
        logic [S0_W-1:0] w_q;
        ctrl_stage_reg #(.W(S0_W)) u_reg (
          .i_clk   (clk),
          .i_reset (reset),
          .i_clr   (flush_e),
          .i_d     ({rs2_d, rs1_d, w_fl_d, rd_d, ctrl_d}),
          .o_q     (w_q)
        );
        assign w_rec[0] = w_q[REC_W-1:0];
        assign w_rs1_e  = w_q[REC_W +: REG_AW];
        assign w_rs2_e  = w_q[REC_W+REG_AW +: REG_AW];
      end else begin : g_x
        ctrl_stage_reg #(.W(REC_W)) u_reg (
          .i_clk   (clk),
          .i_reset (reset),
          .i_clr   (1'b0),
          .i_d     (w_rec[k-1]),
          .o_q     (w_rec[k])
        );
      end
      assign w_fl     = stg_flags_t'(w_rec[k][FL_LSB +: FLAGS_W]);
      assign w_vld[k] = w_fl.valid;
      assign w_rw[k]  = w_fl.regwrite;
      assign w_ld[k]  = w_fl.load;
      assign w_rd[k]  = w_rec[k][RD_LSB +: REG_AW];
      assign ctrl_q[k*CTRL_W +: CTRL_W] = w_rec[k][CTRL_W-1:0];
    end
  endgenerate

  // ---- hazard detection: only loads not yet forwardable by the time D reaches E
  always_comb begin
    w_lu = 1'b0;
    for (int j = 0; j < LOAD_LAT - 1; j++) begin
      if (w_vld[j] && w_ld[j] && (w_rd[j] != '0) &&
          ((w_rd[j] == rs1_d) || (w_rd[j] == rs2_d)))
        w_lu = 1'b1;
    end
    w_lu = w_lu & valid_d;
  end

  assign w_br    = pcsrc_e & w_vld[STG_E];
  assign flush_d = w_br;
  assign flush_e = w_br | w_lu;
  assign stall_f = w_lu & ~w_br;
  assign stall_d = w_lu & ~w_br;

  // Scanning from the oldest stage down leaves the youngest match selected.
  always_comb begin
    fwd_a_e = FW'(FWD_RF);
    fwd_b_e = FW'(FWD_RF);
    for (int s = DEPTH - 1; s >= STG_M; s--) begin
      if (w_vld[s] && w_rw[s] && (w_rd[s] != '0) && !(w_ld[s] && (s < LOAD_LAT))) begin
        if (w_rd[s] == w_rs1_e) fwd_a_e = FW'(s);
        if (w_rd[s] == w_rs2_e) fwd_b_e = FW'(s);
      end
    end
  end

  // ---- performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_br)          r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_lu && !w_br) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign valid_q    = w_vld;
  assign rd_w       = w_rd[DEPTH-1];
  assign regwrite_w = w_vld[DEPTH-1] & w_rw[DEPTH-1];
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: two configurations (3/2 and 5/3) share one stimulus
// stream, checked every cycle against a behavioural model plus directed literals.
module tb_ctrl_pipe_hazard;

  localparam int CW = 16;
  localparam int AW = 5;
  localparam int DA = 3;
  localparam int LA = 2;
  localparam int FA = $clog2(DA);
  localparam int DB = 5;
  localparam int LB = 3;
  localparam int FB = $clog2(DB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          valid_d = 1'b0, regwrite_d = 1'b0, load_d = 1'b0, pcsrc_e = 1'b0;
  logic [CW-1:0] ctrl_d = '0;
  logic [AW-1:0] rd_d = '0, rs1_d = '0, rs2_d = '0;

  logic [DA*CW-1:0] ctrl_qA;
  logic [DA-1:0]    valid_qA;
  logic [AW-1:0]    rd_wA;
  logic             regwrite_wA, stall_fA, stall_dA, flush_dA, flush_eA;
  logic [FA-1:0]    fwd_aA, fwd_bA;
  logic [31:0]      stall_cntA, flush_cntA;

  logic [DB*CW-1:0] ctrl_qB;
  logic [DB-1:0]    valid_qB;
  logic [AW-1:0]    rd_wB;
  logic             regwrite_wB, stall_fB, stall_dB, flush_dB, flush_eB;
  logic [FB-1:0]    fwd_aB, fwd_bB;
  logic [31:0]      stall_cntB, flush_cntB;

  ctrl_pipe_hazard #(.CTRL_W(CW), .DEPTH(DA), .REG_AW(AW), .LOAD_LAT(LA), .FW(FA)) dut_a (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .rd_d(rd_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .regwrite_d(regwrite_d), .load_d(load_d),
    .pcsrc_e(pcsrc_e), .ctrl_q(ctrl_qA), .valid_q(valid_qA), .rd_w(rd_wA),
    .regwrite_w(regwrite_wA), .stall_f(stall_fA), .stall_d(stall_dA),
    .flush_d(flush_dA), .flush_e(flush_eA), .fwd_a_e(fwd_aA), .fwd_b_e(fwd_bA),
    .stall_cnt(stall_cntA), .flush_cnt(flush_cntA));

  ctrl_pipe_hazard #(.CTRL_W(CW), .DEPTH(DB), .REG_AW(AW), .LOAD_LAT(LB), .FW(FB)) dut_b (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .rd_d(rd_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .regwrite_d(regwrite_d), .load_d(load_d),
    .pcsrc_e(pcsrc_e), .ctrl_q(ctrl_qB), .valid_q(valid_qB), .rd_w(rd_wB),
    .regwrite_w(regwrite_wB), .stall_f(stall_fB), .stall_d(stall_dB),
    .flush_d(flush_dB), .flush_e(flush_eB), .fwd_a_e(fwd_aB), .fwd_b_e(fwd_bB),
    .stall_cnt(stall_cntB), .flush_cnt(flush_cntB));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model: per-config list of in-flight instructions, stage 0 = E
  typedef struct {
    bit          v, rw, ld;
    bit [AW-1:0] rd, rs1, rs2;
    bit [CW-1:0] ctrl;
  } mrec_t;

  mrec_t       mdl [2][8];
  int unsigned m_scnt [2];
  int unsigned m_fcnt [2];
  int          mdep [2] = '{DA, DB};
  int          mll  [2] = '{LA, LB};
  bit          m_live = 1'b0;

  function automatic bit m_lu(int u);
    bit hit = 1'b0;
    if (!valid_d) return 1'b0;
    for (int j = 0; j < mll[u] - 1; j++)
      if (mdl[u][j].v && mdl[u][j].ld && mdl[u][j].rd != 0 &&
          (mdl[u][j].rd == rs1_d || mdl[u][j].rd == rs2_d)) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit m_br(int u);
    return pcsrc_e && mdl[u][0].v;
  endfunction

  function automatic int m_fwd(int u, bit [AW-1:0] rs);
    if (rs == 0) return 0;
    for (int k = 1; k < mdep[u]; k++)
      if (mdl[u][k].v && mdl[u][k].rw && mdl[u][k].rd == rs &&
          !(mdl[u][k].ld && k < mll[u])) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        for (int k = 0; k < 8; k++) mdl[u][k] = '{default: 0};
        m_scnt[u] = 0;
        m_fcnt[u] = 0;
      end else begin
        bit lu, br;
        lu = m_lu(u);
        br = m_br(u);
        if (br && m_fcnt[u] != 32'hFFFF_FFFF) m_fcnt[u]++;
        if (lu && !br && m_scnt[u] != 32'hFFFF_FFFF) m_scnt[u]++;
        for (int k = mdep[u] - 1; k >= 1; k--) mdl[u][k] = mdl[u][k-1];
        if (br || lu) mdl[u][0] = '{default: 0};
        else mdl[u][0] = '{v: valid_d, rw: regwrite_d, ld: load_d, rd: rd_d,
                           rs1: rs1_d, rs2: rs2_d, ctrl: ctrl_d};
      end
    end
    if (reset) m_live = 1'b1;
  end

  // ---- per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      bit luA, brA, luB, brB;
      luA = m_lu(0); brA = m_br(0);
      luB = m_lu(1); brB = m_br(1);
      for (int k = 0; k < DA; k++) begin
        chk("A.valid_q", valid_qA[k], mdl[0][k].v);
        chk("A.ctrl_q", ctrl_qA[k*CW +: CW], mdl[0][k].ctrl);
      end
      chk("A.regwrite_w", regwrite_wA, mdl[0][DA-1].v && mdl[0][DA-1].rw);
      if (mdl[0][DA-1].v && mdl[0][DA-1].rw) chk("A.rd_w", rd_wA, mdl[0][DA-1].rd);
      chk("A.stall_f", stall_fA, luA && !brA);
      chk("A.stall_d", stall_dA, luA && !brA);
      chk("A.flush_d", flush_dA, brA);
      chk("A.flush_e", flush_eA, brA || luA);
      if (mdl[0][0].v) begin
        chk("A.fwd_a", fwd_aA, m_fwd(0, mdl[0][0].rs1));
        chk("A.fwd_b", fwd_bA, m_fwd(0, mdl[0][0].rs2));
      end
      chk("A.stall_cnt", stall_cntA, m_scnt[0]);
      chk("A.flush_cnt", flush_cntA, m_fcnt[0]);
      for (int k = 0; k < DB; k++) begin
        chk("B.valid_q", valid_qB[k], mdl[1][k].v);
        chk("B.ctrl_q", ctrl_qB[k*CW +: CW], mdl[1][k].ctrl);
      end
      chk("B.regwrite_w", regwrite_wB, mdl[1][DB-1].v && mdl[1][DB-1].rw);
      if (mdl[1][DB-1].v && mdl[1][DB-1].rw) chk("B.rd_w", rd_wB, mdl[1][DB-1].rd);
      chk("B.stall_f", stall_fB, luB && !brB);
      chk("B.stall_d", stall_dB, luB && !brB);
      chk("B.flush_d", flush_dB, brB);
      chk("B.flush_e", flush_eB, brB || luB);
      if (mdl[1][0].v) begin
        chk("B.fwd_a", fwd_aB, m_fwd(1, mdl[1][0].rs1));
        chk("B.fwd_b", fwd_bB, m_fwd(1, mdl[1][0].rs2));
      end
      chk("B.stall_cnt", stall_cntB, m_scnt[1]);
      chk("B.flush_cnt", flush_cntB, m_fcnt[1]);
    end
  end

  // ---- directed stimulus: inputs change 2 time units after each rising edge
  logic [CW-1:0] tag = 16'hA000;

  task automatic put(input bit rst, input bit v, input bit [AW-1:0] rd,
                     input bit [AW-1:0] rs1, input bit [AW-1:0] rs2,
                     input bit rw, input bit ld, input bit pc);
    @(posedge clk);
    #2;
    tag        = tag + 16'd1;
    reset      = rst;
    valid_d    = v;
    rd_d       = rd;
    rs1_d      = rs1;
    rs2_d      = rs2;
    regwrite_d = rw;
    load_d     = ld;
    pcsrc_e    = pc;
    ctrl_d     = tag;
    #1;
  endtask

  task automatic bubble(input bit rst);
    put(rst, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset, then three NOPs
    bubble(1'b1);
    bubble(1'b1);
    bubble(1'b0);
    chk("rst.valid_qA", valid_qA, 3'b000);
    chk("rst.stall_cntA", stall_cntA, 32'd0);
    chk("rst.flush_eA", flush_eA, 1'b0);
    chk("rst.fwd_aA", fwd_aA, 2'd0);
    for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    // load x5
    put(1'b0, 1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    chk("nop.valid_qA", valid_qA, 3'b111);
    chk("nop.stall_fA", stall_fA, 1'b0);
    // dependent add x6 = x5 + x0, re-presented while stalled
    put(1'b0, 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu.stall_fA", stall_fA, 1'b1);
    chk("lu.stall_dA", stall_dA, 1'b1);
    chk("lu.flush_eA", flush_eA, 1'b1);
    chk("lu.flush_dA", flush_dA, 1'b0);
    put(1'b0, 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu.after_stall_fA", stall_fA, 1'b0);
    chk("lu.stall_cntA", stall_cntA, 32'd1);
    chk("lu2.stall_fB", stall_fB, 1'b1);
    put(1'b0, 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu.fwd_aA", fwd_aA, 2'd2);
    chk("lu2.stall_fB_end", stall_fB, 1'b0);
    chk("lu2.stall_cntB", stall_cntB, 32'd2);
    bubble(1'b0);
    chk("lu2.fwd_aB", fwd_aB, 3'd3);
    // ALU-ALU forwarding from M, then rd=x0 producer with x0 sources
    put(1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    put(1'b0, 1'b1, 5'd4, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    bubble(1'b0);
    chk("alu.fwd_aA", fwd_aA, 2'd1);
    chk("alu.fwd_bA", fwd_bA, 2'd1);
    chk("alu.fwd_aB", fwd_aB, 3'd1);
    put(1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    put(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    bubble(1'b0);
    chk("x0.fwd_aA", fwd_aA, 2'd0);
    chk("x0.fwd_bA", fwd_bA, 2'd0);
    // taken branch in E coinciding with a load-use pair
    put(1'b0, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    put(1'b0, 1'b1, 5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("br.flush_dA", flush_dA, 1'b1);
    chk("br.flush_eA", flush_eA, 1'b1);
    chk("br.stall_fA", stall_fA, 1'b0);
    chk("br.stall_dA", stall_dA, 1'b0);
    bubble(1'b0);
    chk("br.flush_cntA", flush_cntA, 32'd1);
    chk("br.stall_cntA", stall_cntA, 32'd1);
    chk("br.flush_cntB", flush_cntB, 32'd1);
    chk("br.stall_cntB", stall_cntB, 32'd2);
    // reset asserted in the middle of a stall
    put(1'b0, 1'b1, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    put(1'b1, 1'b1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("rs.stall_fA_pre", stall_fA, 1'b1);
    bubble(1'b0);
    chk("rs.valid_qA", valid_qA, 3'b000);
    chk("rs.valid_qB", valid_qB, 5'b00000);
    chk("rs.stall_fA", stall_fA, 1'b0);
    chk("rs.stall_cntA", stall_cntA, 32'd0);
    chk("rs.flush_cntA", flush_cntA, 32'd0);
    chk("rs.stall_cntB", stall_cntB, 32'd0);
    for (int i = 0; i < 6; i++) bubble(1'b0);
    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
